// File: rtl/ram1_pkg.sv
// Shared types and helpers for the ram1 scratch store.
// Optional stored-parity feature is enabled with RAM1_PARITY_EN.
package ram1_pkg;

    localparam int RAM1_ADDR_W = 8;
    localparam int RAM1_DATA_W = 8;
    localparam int RAM1_PAR_MAX_W = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram1_state_t;

    // Even parity: the returned bit makes the XOR over {bit, data} zero.
    function automatic logic ram1_parity(input logic [RAM1_PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram1_clear_ctrl.sv
// Post-reset clear sequencer: walks every address writing zero, then hands
// the single write port over to the user interface and drops busy.
module ram1_clear_ctrl
    import ram1_pkg::*;
#(
    parameter int ADDR_W = RAM1_ADDR_W,
    parameter int DATA_W = RAM1_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    ram1_state_t       state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    // Counter parks on the last address rather than wrapping.
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                READY: begin
                    state_q <= READY;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= CLEAR;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign ready_o = (state_q == READY);

    // Gating with rst_n keeps clocks during reset from touching the array.
    assign we_o    = rst_n && ((state_q == CLEAR) || wr_i);
    assign waddr_o = (state_q == CLEAR) ? clr_addr_q : addr_i;
    assign wdata_o = (state_q == CLEAR) ? '0 : data_i;

endmodule

// File: rtl/ram1.sv
// Single-port 2**ADDR_W x DATA_W RAM with registered read/write-through port.
// Define RAM1_PARITY_EN to store and check an even-parity bit per word.
module ram1
    import ram1_pkg::*;
#(
    parameter int ADDR_W = RAM1_ADDR_W,
    parameter int DATA_W = RAM1_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    output logic              busy,
    output logic              parity_err
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef RAM1_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [MEM_W-1:0]  wword;
    logic [MEM_W-1:0]  rword;

    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0] data_out_q, data_out_d;

    ram1_clear_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_clear_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (wr),
        .addr_i  (addr),
        .data_i  (data_in),
        .busy_o  (busy),
        .ready_o (ready),
        .we_o    (we),
        .waddr_o (waddr),
        .wdata_o (wdata)
    );

`ifdef RAM1_PARITY_EN
    assign wword = {ram1_parity(RAM1_PAR_MAX_W'(wdata)), wdata};
`else
    assign wword = wdata;
`endif

    // Array has no reset; only the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wword;
        end
    end

    assign rword = mem_q[addr];

    always_comb begin
        data_out_d = '0;
        if (ready) begin
            data_out_d = wr ? data_in : rword[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

`ifdef RAM1_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb begin
        parity_err_d = 1'b0;
        if (ready && !wr) begin
            parity_err_d = ^rword;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram1.sv
// Directed, table-driven bench for ram1: clear sequence, fill/readback,
// write-through, busy lockout, mid-stream reset and (optionally) parity.
module tb_ram1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_out;
    logic [7:0] data_in;
    logic [7:0] addr;
    logic       wr;
    logic       busy;
    logic       parity_err;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[$];

    ram1 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_out   (data_out),
        .data_in    (data_in),
        .addr       (addr),
        .wr         (wr),
        .busy       (busy),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one access, clock it, and sample 1ns after the edge.
    task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d);
        wr = w; addr = a; data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Release reset and check busy / data_out across the 256-edge clear.
    task automatic run_clear(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 256; e++) begin
            @(posedge clk);
            #1;
            check({tag, "_busy"}, {7'd0, busy}, (e < 256) ? 8'd1 : 8'd0);
            check({tag, "_dout_zero"}, data_out, 8'h00);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr = 1'b1; addr = 8'd5; data_in = 8'h33;   // held through clear: must be ignored
        #12;
        check("reset_dout", data_out, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'd1);
        check("reset_perr", {7'd0, parity_err}, 8'd0);
        @(posedge clk);
        #1;
        check("reset_busy_clocked", {7'd0, busy}, 8'd1);

        run_clear("clr1");

        access(1'b0, 8'd5, 8'h00);
        check("lockout_addr5", data_out, 8'h00);
        for (int a = 0; a < 256; a++) begin
            access(1'b0, 8'(a), 8'hFF);
            check("clear_readback", data_out, 8'h00);
        end

        for (int k = 0; k < 40; k++)
            vecs.push_back('{1'b1, 8'(k + 10), 8'(k + 1), 8'(k + 1), 1'b0});
        vecs.push_back('{1'b0, 8'd10,  8'hEE, 8'd1,  1'b0});
        vecs.push_back('{1'b0, 8'd49,  8'hEE, 8'd40, 1'b0});
        vecs.push_back('{1'b0, 8'd50,  8'hEE, 8'd0,  1'b0});
        vecs.push_back('{1'b1, 8'h80,  8'hA5, 8'hA5, 1'b0});
        vecs.push_back('{1'b0, 8'h80,  8'h00, 8'hA5, 1'b0});
        vecs.push_back('{1'b0, 8'd25,  8'h00, 8'd16, 1'b0});
        vecs.push_back('{1'b1, 8'd255, 8'h5A, 8'h5A, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'd255, 8'h00, 8'h5A, 1'b0});
        foreach (vecs[i]) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].din);
            check("vec_dout", data_out, vecs[i].exp_dout);
            check("vec_perr", {7'd0, parity_err}, {7'd0, vecs[i].exp_perr});
            check("vec_busy", {7'd0, busy}, 8'd0);
        end

        // Mid-stream reset aborts and reruns the clear.
        access(1'b1, 8'd3, 8'h77);
        check("mid_write", data_out, 8'h77);
        wr = 1'b1; addr = 8'd3; data_in = 8'h77;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dout", data_out, 8'h00);
        check("mid_rst_busy", {7'd0, busy}, 8'd1);
        @(posedge clk);
        #1;
        check("mid_rst_hold", data_out, 8'h00);
        run_clear("clr2");
        access(1'b0, 8'd3, 8'h00);
        check("mid_addr3", data_out, 8'h00);
        access(1'b0, 8'h80, 8'h00);
        check("mid_addr80", data_out, 8'h00);

`ifdef RAM1_PARITY_EN
        access(1'b1, 8'd7, 8'h0F);
        check("par_write_perr", {7'd0, parity_err}, 8'd0);
        access(1'b1, 8'd8, 8'h0F);
        dut.mem_q[7][0] = ~dut.mem_q[7][0];
        access(1'b0, 8'd7, 8'h00);
        check("par_bad_dout", data_out, 8'h0E);
        check("par_bad_perr", {7'd0, parity_err}, 8'd1);
        access(1'b0, 8'd8, 8'h00);
        check("par_good_dout", data_out, 8'h0F);
        check("par_good_perr", {7'd0, parity_err}, 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
